pulse_shaper: RTL
=================

# pulse_shaper

Output-side counterpart of the input conditioning logic. It converts short internal event requests (single-cycle or level) into clean, slow external pulses with a guaranteed minimum high time and minimum low gap, suitable for relays, buzzers, LEDs or motor drivers on the pipe-cleaning robot. Requests arriving while a pulse is in progress are queued up to a fixed depth and replayed back-to-back; excess requests are flagged.

## Interface

- `CNT_W`, 20: width of the internal timing counter.
- `HOLD_CYCLES`, 1000000: clock cycles `pulse_out` stays high per pulse; 1 ≤ value < 2^CNT_W.
- `GAP_CYCLES`, 500000: clock cycles `pulse_out` stays low after each pulse; 1 ≤ value < 2^CNT_W.
- `PEND_W`, 2: width of the pending-request counter.
- `MAX_PENDING`, 3: maximum queued requests; 1 ≤ value ≤ 2^PEND_W − 1.

Ports:

- `clk` input 1: system clock. All state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `trigger` input 1: synchronous event request; each rising edge is one request.
- `pulse_out` output 1: shaped external pulse.
- `busy` output 1: high whenever the state is not IDLE.
- `pending` output PEND_W: number of queued requests not yet started.
- `overflow` output 1: sticky; set when a request is dropped.
- `pulse_count` output 8: number of completed pulses, wrapping modulo 256.

## Operation

- Edge detect: `trig_prev` registers `trigger`. A request exists in a cycle when `trigger && !trig_prev`. `trig_prev` resets to 0, so `trigger` held high through reset release counts as one request.
- States:
  - IDLE: `pulse_out`=0, counter=0.
  - On a request, go to HOLD, set `pulse_out`=1 and counter=0.
- HOLD:
  - Counter increments each cycle.
  - When counter == HOLD_CYCLES−1, go to GAP, set `pulse_out`=0, counter=0, and increment `pulse_count`.
- GAP:
  - Counter increments each cycle.
  - When counter == GAP_CYCLES−1:
    - If `pending`>0, decrement `pending` and go to HOLD (`pulse_out`=1, counter=0).
    - Else, if a request exists this cycle, go to HOLD directly without consuming `pending`.
    - Else, go to IDLE.
- Requests in HOLD or GAP:
  - If `pending` < MAX_PENDING, increment `pending`.
  - Otherwise set `overflow`=1 and drop the request.
- Simultaneous events:
  - Request plus dequeue in the same cycle: `pending` is unchanged and no overflow, even at MAX_PENDING.
  - Request in the IDLE cycle is never queued; it starts HOLD immediately.
- `overflow` clears only on reset.
- Counter arithmetic is unsigned CNT_W bits. Compare with ==; the counter never exceeds max(HOLD_CYCLES, GAP_CYCLES)−1.
- Reset asserted mid-pulse:
  - All outputs and state clear immediately (asynchronous). `pulse_out` drops without completing.
  - Queued requests are discarded. No `pulse_count` increment.

## Timing

- Reset values: `pulse_out`=0, `busy`=0, `pending`=0, `overflow`=0, `pulse_count`=0, state IDLE, counter 0, `trig_prev`=0.
- Latency: a request sampled at rising edge k drives `pulse_out` high after edge k, so it is visible in cycle k+1.
- `pulse_out` is high for exactly HOLD_CYCLES cycles, then low for at least GAP_CYCLES cycles.
- Back-to-back queued pulses have a period of exactly HOLD_CYCLES+GAP_CYCLES.
- `busy` rises with `pulse_out`. It falls on the edge after the last GAP cycle when nothing is pending.
- `pulse_count` increments on the same edge that `pulse_out` falls.
- All outputs are registered; no combinational path from `trigger` to any output.

## Test plan

Run with HOLD_CYCLES=4, GAP_CYCLES=3, MAX_PENDING=2, PEND_W=2.

- Reset sequence:
  - Stimulus: assert `reset`=0 asynchronously between clock edges while `pulse_out`=1 and `pending`=1.
  - Required response: all outputs 0 immediately; after release, IDLE with no replay of queued work.
- Single request:
  - Stimulus: 1-cycle `trigger` at edge 10.
  - Required response: `pulse_out` high in cycles 11–14, low from 15; `busy` low from cycle 18; `pulse_count`=1.
- Level trigger:
  - Stimulus: `trigger` held high for 20 cycles.
  - Required response: exactly one pulse, `pending` stays 0.
  - Stimulus: `trigger` held high through reset release.
  - Required response: one pulse starting on the first edge after release.
- Queueing:
  - Stimulus: 2 requests during HOLD.
  - Required response: `pending`=2; pulses start at cycles 11, 18, 25 (period 7); `pending` returns to 0; `pulse_count`=3; `overflow`=0.
- Overflow:
  - Stimulus: 3 requests during HOLD.
  - Required response: `pending` saturates at 2; `overflow`=1 and stays 1 after all pulses finish; total 3 pulses.
- Boundary cases:
  - Stimulus: request exactly in the last GAP cycle with `pending`=0.
  - Required response: HOLD starts on the next edge, no IDLE cycle, `pending` stays 0.
  - Stimulus: same request with `pending`=2.
  - Required response: `pending` stays 2, `overflow`=0.
  - Stimulus: 256 pulses.
  - Required response: `pulse_count` wraps to 0.

Source files
------------

// File: rtl/pulse_shaper.sv
// pulse_shaper: turns short internal event requests into slow, clean external
// pulses with a fixed high time and a fixed minimum low gap. Requests that
// arrive while a pulse is running are counted and replayed back-to-back.
module pulse_shaper #(
    parameter int CNT_W       = 20,
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int PEND_W      = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [7:0]        pulse_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Terminal counts; the counter restarts at 0 on every phase change.
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             trig_prev;
    logic             req;

    // One request per rising edge of trigger; a level only counts once.
    assign req = trigger & ~trig_prev;

    // Pulse sequencer: phase timing, request queueing and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            trig_prev   <= 1'b0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            pending     <= '0;
            overflow    <= 1'b0;
            pulse_count <= '0;
        end else begin
            trig_prev <= trigger;
            case (state)
                IDLE: begin
                    // An idle request is never queued; it starts the pulse now.
                    if (req) begin
                        state     <= HOLD;
                        pulse_out <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state       <= GAP;
                        pulse_out   <= 1'b0;
                        cnt         <= '0;
                        pulse_count <= pulse_count + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (req) begin
                        if (pending < PEND_MAX) pending <= pending + PEND_W'(1);
                        else                    overflow <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (pending != '0) begin
                            // A request landing on the dequeue cycle replaces the
                            // dequeued slot, so the count holds and nothing drops.
                            if (!req) pending <= pending - PEND_W'(1);
                            state     <= HOLD;
                            pulse_out <= 1'b1;
                            cnt       <= '0;
                        end else if (req) begin
                            state     <= HOLD;
                            pulse_out <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (req) begin
                            if (pending < PEND_MAX) pending <= pending + PEND_W'(1);
                            else                    overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
